ct_f_spsram_param: RTL and testbench

CT_F_SPSRAM_PARAM -- requirements
Module: ct_f_spsram_param

---
 rtl/ct_f_spsram_param.sv | 128 ++++++++++++
 tb/tb_ct_f_spsram_param.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_f_spsram_param.sv
// Single-port SRAM with per-bit write mask, write-first read behaviour,
// optional output pipeline register and a post-reset clear engine that
// writes INIT_VALUE into every entry before user accesses are accepted.
module ct_f_spsram_param #(
   parameter int unsigned           DATA_WIDTH = 59,
   parameter int unsigned           ADDR_WIDTH = 8,
   parameter bit                    OUT_REG    = 1'b0,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [ADDR_WIDTH-1:0] A,
   input  logic                  CEN,
   input  logic                  GWEN,
   input  logic [DATA_WIDTH-1:0] WEN,
   input  logic [DATA_WIDTH-1:0] D,
   output logic [DATA_WIDTH-1:0] Q,
   output logic                  INIT_DONE
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [ADDR_WIDTH-1:0] cnt_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  rd_valid_q;
   logic                  done_q;
   logic                  init_we;
   logic                  acc_en;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Next-state and access qualification; a reset cycle suppresses every access.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      state_d = state_q;
      init_we = 1'b0;
      acc_en  = 1'b0;
      wr_en   = 1'b0;
      case (state_q)
         ST_INIT: begin
            init_we = ~RST;
            if (&cnt_q) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            acc_en = ~RST & ~CEN;
            wr_en  = ~RST & ~CEN & ~GWEN;
         end
         default: state_d = ST_INIT;
      endcase
   end

   // State, clear counter, done flag and the address-holding register.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values of its peers.
      if (RST) begin
         state_q    <= ST_INIT;
         cnt_q      <= '0;
         done_q     <= 1'b0;
         addr_q     <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_d == ST_RUN);
         if (state_q == ST_INIT) begin
            cnt_q <= cnt_q + ADDR_WIDTH'(1);
         end
         if (acc_en) begin
            addr_q     <= A;
            rd_valid_q <= 1'b1;
         end
      end
   end

   // Array writes: clear engine during INIT, masked user writes during RUN.
   always_ff @(posedge CLK) begin
      // NOTE: the array is deliberately not reset; its contents are defined by
      // the clear engine, which keeps it mappable onto plain RAM macros.
      if (init_we) begin
         mem[cnt_q] <= INIT_VALUE;
      end else if (wr_en) begin
         mem[A] <= (mem[A] & WEN) | (D & ~WEN);
      end
   end

   // Read register: the latched address plus a valid flag. The array can only
   // change on an access edge, which also re-latches the address, so this
   // always equals the (post-write) word of the last access and holds while
   // CEN is high. Before any access since reset it reads as zero.
   always_comb begin
      rd_word = '0;
      if (rd_valid_q) begin
         rd_word = mem[addr_q];
      end
   end

   generate
      if (OUT_REG) begin : g_out_reg
         logic [DATA_WIDTH-1:0] q_q;

         // Extra output pipeline stage.
         always_ff @(posedge CLK) begin
            if (RST) begin
               q_q <= '0;
            end else begin
               q_q <= rd_word;
            end
         end

         assign Q = q_q;
      end else begin : g_no_out_reg
         assign Q = rd_word;
      end
   endgenerate

   assign INIT_DONE = done_q;

endmodule

// File: tb/tb_ct_f_spsram_param.sv
// Self-checking bench for ct_f_spsram_param: four instances (default
// geometry with and without output register, 1-bit x 2 and 64-bit x 1024),
// a behavioural model per instance feeding a scoreboard, plus directed checks.
module tb_ct_f_spsram_param;

   logic        CLK;
   logic        RST;
   logic [9:0]  a_i    [4];
   logic        cen_i  [4];
   logic        gwen_i [4];
   logic [63:0] wen_i  [4];
   logic [63:0] d_i    [4];

   logic [58:0] q0;
   logic [58:0] q1;
   logic [0:0]  q2;
   logic [63:0] q3;
   logic [3:0]  done_w;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int          due;
      int          dut;
      bit          is_done;
      logic [63:0] exp;
      string       tag;
   } sb_t;

   sb_t sb[$];

   // behavioural model state per instance
   logic [63:0] mm    [4][1024];
   bit          m_run [4];
   int          m_cnt [4];
   logic [63:0] m_rd  [4];
   logic [63:0] m_qr  [4];

   ct_f_spsram_param #(.DATA_WIDTH(59), .ADDR_WIDTH(8), .OUT_REG(1'b0)) u_dut0 (
      .CLK(CLK), .RST(RST), .A(a_i[0][7:0]), .CEN(cen_i[0]), .GWEN(gwen_i[0]),
      .WEN(wen_i[0][58:0]), .D(d_i[0][58:0]), .Q(q0), .INIT_DONE(done_w[0]));

   ct_f_spsram_param #(.DATA_WIDTH(59), .ADDR_WIDTH(8), .OUT_REG(1'b1)) u_dut1 (
      .CLK(CLK), .RST(RST), .A(a_i[1][7:0]), .CEN(cen_i[1]), .GWEN(gwen_i[1]),
      .WEN(wen_i[1][58:0]), .D(d_i[1][58:0]), .Q(q1), .INIT_DONE(done_w[1]));

   ct_f_spsram_param #(.DATA_WIDTH(1), .ADDR_WIDTH(1), .OUT_REG(1'b0)) u_dut2 (
      .CLK(CLK), .RST(RST), .A(a_i[2][0:0]), .CEN(cen_i[2]), .GWEN(gwen_i[2]),
      .WEN(wen_i[2][0:0]), .D(d_i[2][0:0]), .Q(q2), .INIT_DONE(done_w[2]));

   ct_f_spsram_param #(.DATA_WIDTH(64), .ADDR_WIDTH(10), .OUT_REG(1'b0)) u_dut3 (
      .CLK(CLK), .RST(RST), .A(a_i[3]), .CEN(cen_i[3]), .GWEN(gwen_i[3]),
      .WEN(wen_i[3]), .D(d_i[3]), .Q(q3), .INIT_DONE(done_w[3]));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic int dw(input int k);
      case (k)
         0, 1:    return 59;
         2:       return 1;
         default: return 64;
      endcase
   endfunction

   function automatic int depth(input int k);
      case (k)
         0, 1:    return 256;
         2:       return 2;
         default: return 1024;
      endcase
   endfunction

   function automatic logic [63:0] wmask(input int k);
      if (dw(k) == 64) return '1;
      return (64'd1 << dw(k)) - 64'd1;
   endfunction

   function automatic logic [63:0] obs(input int k, input bit is_done);
      if (is_done) return {63'd0, done_w[k]};
      case (k)
         0:       return {5'd0, q0};
         1:       return {5'd0, q1};
         2:       return {63'd0, q2};
         default: return q3;
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, observed, expected);
      end
   endtask

   // Model of one clock edge for instance k, using the currently driven inputs.
   task automatic model_edge(input int k);
      int ad;
      if (RST) begin
         m_run[k] = 1'b0;
         m_cnt[k] = 0;
         m_rd[k]  = '0;
         m_qr[k]  = '0;
      end else begin
         m_qr[k] = m_rd[k];
         if (!m_run[k]) begin
            mm[k][m_cnt[k]] = '0;
            if (m_cnt[k] == depth(k) - 1) m_run[k] = 1'b1;
            m_cnt[k]++;
         end else if (!cen_i[k]) begin
            ad = int'(a_i[k]) % depth(k);
            if (!gwen_i[k]) begin
               mm[k][ad] = ((mm[k][ad] & wen_i[k]) | (d_i[k] & ~wen_i[k])) & wmask(k);
            end
            m_rd[k] = mm[k][ad];
         end
      end
   endtask

   // Advance one clock: model the edge, queue expectations, then at the
   // following falling edge retire everything that is due.
   task automatic cycle(input string tag);
      sb_t e;
      sb_t keep[$];
      for (int k = 0; k < 4; k++) begin
         model_edge(k);
         e.due     = cyc + 1;
         e.dut     = k;
         e.is_done = 1'b0;
         e.exp     = (k == 1) ? m_qr[k] : m_rd[k];
         e.tag     = {tag, "_q"};
         sb.push_back(e);
         e.is_done = 1'b1;
         e.exp     = {63'd0, m_run[k]};
         e.tag     = {tag, "_done"};
         sb.push_back(e);
      end
      @(negedge CLK);
      cyc++;
      foreach (sb[i]) begin
         if (sb[i].due == cyc) check(sb[i].tag, obs(sb[i].dut, sb[i].is_done), sb[i].exp);
         else keep.push_back(sb[i]);
      end
      sb = keep;
   endtask

   task automatic set_main(input logic cen, input logic gwen, input logic [9:0] a,
                           input logic [63:0] wen, input logic [63:0] d);
      for (int k = 0; k < 2; k++) begin
         cen_i[k]  = cen;
         gwen_i[k] = gwen;
         a_i[k]    = a;
         wen_i[k]  = wen;
         d_i[k]    = d;
      end
   endtask

   task automatic set_rand(input int k);
      int sel;
      cen_i[k]  = ($urandom_range(3) == 0);
      gwen_i[k] = 1'($urandom_range(1));
      a_i[k]    = 10'($urandom_range(depth(k) - 1));
      d_i[k]    = {$urandom(), $urandom()};
      sel       = $urandom_range(3);
      if (sel == 0)      wen_i[k] = '0;
      else if (sel == 1) wen_i[k] = '1;
      else               wen_i[k] = {$urandom(), $urandom()};
   endtask

   initial begin
      RST = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cen_i[k]  = 1'b1;
         gwen_i[k] = 1'b1;
         a_i[k]    = '0;
         wen_i[k]  = '1;
         d_i[k]    = '0;
      end

      // reset state
      cycle("rst");
      cycle("rst");
      check("rst_q0", {5'd0, q0}, 64'd0);
      check("rst_q1", {5'd0, q1}, 64'd0);
      check("rst_done", {63'd0, done_w[0]}, 64'd0);

      // user write to A=0 during INIT must be ignored; RST pulse at init cycle 100
      RST = 1'b0;
      set_main(1'b0, 1'b0, 10'd0, 64'd0, '1);
      repeat (100) cycle("init_wr");
      RST = 1'b1;
      cycle("rst_mid_init");
      RST = 1'b0;
      repeat (255) cycle("init_run");
      check("init_done_low", {63'd0, done_w[0]}, 64'd0);
      cycle("init_last");
      check("init_done_rise", {63'd0, done_w[0]}, 64'd1);

      // every address reads back zero (A=0 first: the ignored INIT write)
      for (int i = 0; i < 256; i++) begin
         set_main(1'b0, 1'b1, 10'(i), '1, 64'd0);
         cycle("read_all");
         check("read_all_zero", {5'd0, q0}, 64'd0);
      end

      // masked write over an all-ones word
      set_main(1'b0, 1'b0, 10'h05A, 64'd0, 64'h07FF_FFFF_FFFF_FFFF);
      cycle("wr_ones");
      set_main(1'b0, 1'b0, 10'h05A, 64'h07FF_FFFF_FFFF_FF00, 64'd0);
      cycle("wr_mask");
      set_main(1'b0, 1'b1, 10'h05A, '1, 64'd0);
      cycle("rd_mask");
      check("masked_write", {5'd0, q0}, 64'h07FF_FFFF_FFFF_FF00);

      // write-first to A=3, then hold while CEN is high and A toggles
      set_main(1'b0, 1'b0, 10'd3, 64'd0, 64'h123);
      cycle("wr3");
      check("write_first", {5'd0, q0}, 64'h123);
      for (int i = 0; i < 5; i++) begin
         set_main(1'b1, 1'($urandom_range(1)), (i % 2 == 0) ? 10'hFF : 10'h00,
                  {$urandom(), $urandom()}, {$urandom(), $urandom()});
         cycle("cen_hold");
         check("cen_hold", {5'd0, q0}, 64'h123);
      end

      // output-register latency: read 5A, then 3
      set_main(1'b0, 1'b1, 10'h05A, '1, 64'd0);
      cycle("oreg_rd5a");
      set_main(1'b0, 1'b1, 10'd3, '1, 64'd0);
      cycle("oreg_rd3");
      check("oreg_lat1", {5'd0, q1}, 64'h07FF_FFFF_FFFF_FF00);
      check("noreg_lat1", {5'd0, q0}, 64'h123);
      set_main(1'b1, 1'b1, 10'd0, '1, 64'd0);
      cycle("oreg_wait");
      check("oreg_lat2", {5'd0, q1}, 64'h123);

      // GWEN=0 with WEN all ones: no update, read register loads mem[A]
      set_main(1'b0, 1'b0, 10'h05A, '1, {$urandom(), $urandom()});
      cycle("wen_ones");
      check("wen_all_ones", {5'd0, q0}, 64'h07FF_FFFF_FFFF_FF00);

      // back-to-back write then read, same address
      set_main(1'b0, 1'b0, 10'd10, 64'd0, 64'h456);
      cycle("b2b_wr");
      set_main(1'b0, 1'b1, 10'd10, '1, 64'd0);
      cycle("b2b_rd");
      check("b2b_read", {5'd0, q0}, 64'h456);

      // wait for the 1024-entry instance to finish its clear
      set_main(1'b1, 1'b1, 10'd0, '1, 64'd0);
      for (int i = 0; i < 2000 && done_w[3] !== 1'b1; i++) cycle("wait_b");
      check("sweep_b_done", {63'd0, done_w[3]}, 64'd1);

      // random masked accesses on every instance against the model
      for (int n = 0; n < 600; n++) begin
         set_rand(0);
         set_rand(2);
         set_rand(3);
         set_main(cen_i[0], gwen_i[0], a_i[0], wen_i[0], d_i[0]);
         cycle("rand");
      end

      // reset in RUN discards the same-cycle write and re-runs the clear
      RST = 1'b1;
      set_main(1'b0, 1'b0, 10'd9, 64'd0, 64'hABC);
      for (int k = 2; k < 4; k++) cen_i[k] = 1'b1;
      cycle("rst_run");
      RST = 1'b0;
      set_main(1'b1, 1'b1, 10'd0, '1, 64'd0);
      for (int i = 0; i < 400 && done_w[0] !== 1'b1; i++) cycle("reinit");
      check("reinit_done", {63'd0, done_w[0]}, 64'd1);
      set_main(1'b0, 1'b1, 10'd9, '1, 64'd0);
      cycle("rd_after_rst");
      check("rst_discard", {5'd0, q0}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
